// File: rtl/vga_timing.sv
// Free-running 1024x768@60 raster timing generator: pixel/line counters, sync and blanking
// flags, line/frame markers and a completed-frame counter, all registered together.

package vga_pkg;
   localparam int HBLANK_START = 1024;
   localparam int HBLANK_STOP  = 1344;
   localparam int HSYNC_START  = 1048;
   localparam int HSYNC_STOP   = 1184;
   localparam int VBLANK_START = 768;
   localparam int VBLANK_STOP  = 806;
   localparam int VSYNC_START  = 771;
   localparam int VSYNC_STOP   = 777;
endpackage

module vga_timing #(
   parameter int H_ACTIVE   = vga_pkg::HBLANK_START,
   parameter int H_TOTAL    = vga_pkg::HBLANK_STOP,
   parameter int H_SYNC_ON  = vga_pkg::HSYNC_START,
   parameter int H_SYNC_OFF = vga_pkg::HSYNC_STOP,
   parameter int V_ACTIVE   = vga_pkg::VBLANK_START,
   parameter int V_TOTAL    = vga_pkg::VBLANK_STOP,
   parameter int V_SYNC_ON  = vga_pkg::VSYNC_START,
   parameter int V_SYNC_OFF = vga_pkg::VSYNC_STOP,
   parameter int CNT_W      = 11,
   parameter int FRAME_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [CNT_W-1:0]   hcount,
   output logic [CNT_W-1:0]   vcount,
   output logic               hsync,
   output logic               vsync,
   output logic               hblnk,
   output logic               vblnk,
   output logic               line_start,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_cnt
);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_ON_C  = CNT_W'(H_SYNC_ON);
   localparam logic [CNT_W-1:0] HS_OFF_C = CNT_W'(H_SYNC_OFF);
   localparam logic [CNT_W-1:0] VS_ON_C  = CNT_W'(V_SYNC_ON);
   localparam logic [CNT_W-1:0] VS_OFF_C = CNT_W'(V_SYNC_OFF);

   generate
      if (!(H_ACTIVE < H_SYNC_ON && H_SYNC_ON < H_SYNC_OFF && H_SYNC_OFF <= H_TOTAL)) begin : g_bad_h
         $error("vga_timing: horizontal timing parameters out of order");
      end
      if (!(V_ACTIVE < V_SYNC_ON && V_SYNC_ON < V_SYNC_OFF && V_SYNC_OFF <= V_TOTAL)) begin : g_bad_v
         $error("vga_timing: vertical timing parameters out of order");
      end
      if (H_TOTAL >= (1 << CNT_W) || V_TOTAL >= (1 << CNT_W)) begin : g_bad_w
         $error("vga_timing: CNT_W too narrow for H_TOTAL/V_TOTAL");
      end
   endgenerate

   logic [CNT_W-1:0]   hcount_next;
   logic [CNT_W-1:0]   vcount_next;
   logic [FRAME_W-1:0] frame_cnt_next;
   logic               hsync_next;
   logic               vsync_next;
   logic               hblnk_next;
   logic               vblnk_next;
   logic               line_start_next;
   logic               frame_start_next;

   always_comb begin
      hcount_next    = hcount;
      vcount_next    = vcount;
      frame_cnt_next = frame_cnt;
      if (en) begin
         if (hcount == H_LAST) begin
            hcount_next = '0;
            if (vcount == V_LAST) begin
               vcount_next    = '0;
               frame_cnt_next = frame_cnt + FRAME_W'(1);
            end else begin
               vcount_next = vcount + CNT_W'(1);
            end
         end else begin
            hcount_next = hcount + CNT_W'(1);
         end
      end
   end

   // Flags decode the next-state counters so they land in the same register stage.
   always_comb begin
      hsync_next       = (hcount_next >= HS_ON_C) && (hcount_next < HS_OFF_C);
      vsync_next       = (vcount_next >= VS_ON_C) && (vcount_next < VS_OFF_C);
      hblnk_next       = (hcount_next >= H_ACT_C);
      vblnk_next       = (vcount_next >= V_ACT_C);
      line_start_next  = (hcount_next == '0);
      frame_start_next = (hcount_next == '0) && (vcount_next == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount      <= '0;
         vcount      <= '0;
         frame_cnt   <= '0;
         hsync       <= 1'b0;
         vsync       <= 1'b0;
         hblnk       <= 1'b0;
         vblnk       <= 1'b0;
         line_start  <= 1'b1;
         frame_start <= 1'b1;
      end else begin
         hcount      <= hcount_next;
         vcount      <= vcount_next;
         frame_cnt   <= frame_cnt_next;
         hsync       <= hsync_next;
         vsync       <= vsync_next;
         hblnk       <= hblnk_next;
         vblnk       <= vblnk_next;
         line_start  <= line_start_next;
         frame_start <= frame_start_next;
      end
   end

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a shrunken-raster instance (FRAME_W=2) for frame-level behaviour and a
// default 1024x768 instance for line-level timing, both scored against a linear-pixel-index model.

module tb_vga_timing;

   localparam int S_HA = 32, S_HSON = 36, S_HSOFF = 42, S_HT = 48;
   localparam int S_VA = 12, S_VSON = 13, S_VSOFF = 15, S_VT = 17, S_FW = 2;
   localparam int D_HA = 1024, D_HSON = 1048, D_HSOFF = 1184, D_HT = 1344;
   localparam int D_VA = 768, D_VSON = 771, D_VSOFF = 777, D_VT = 806, D_FW = 16;

   typedef struct packed {
      logic [15:0] h;
      logic [15:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic        ls;
      logic        fs;
      logic [15:0] fc;
   } obs_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_s = 1'b1, en_s = 1'b0;
   logic [10:0] hc_s, vc_s;
   logic        hs_s, vs_s, hb_s, vb_s, ls_s, fs_s;
   logic [1:0]  fc_s;

   logic        rst_d = 1'b1, en_d = 1'b0;
   logic [10:0] hc_d, vc_d;
   logic        hs_d, vs_d, hb_d, vb_d, ls_d, fs_d;
   logic [15:0] fc_d;

   vga_timing #(
      .H_ACTIVE(S_HA), .H_TOTAL(S_HT), .H_SYNC_ON(S_HSON), .H_SYNC_OFF(S_HSOFF),
      .V_ACTIVE(S_VA), .V_TOTAL(S_VT), .V_SYNC_ON(S_VSON), .V_SYNC_OFF(S_VSOFF),
      .CNT_W(11), .FRAME_W(S_FW)
   ) dut_s (
      .clk(clk), .rst(rst_s), .en(en_s), .hcount(hc_s), .vcount(vc_s),
      .hsync(hs_s), .vsync(vs_s), .hblnk(hb_s), .vblnk(vb_s),
      .line_start(ls_s), .frame_start(fs_s), .frame_cnt(fc_s)
   );

   vga_timing dut_d (
      .clk(clk), .rst(rst_d), .en(en_d), .hcount(hc_d), .vcount(vc_d),
      .hsync(hs_d), .vsync(vs_d), .hblnk(hb_d), .vblnk(vb_d),
      .line_start(ls_d), .frame_start(fs_d), .frame_cnt(fc_d)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference: raster position is a single pixel index within the frame.
   function automatic obs_t model(int p, int fr, int ha, int hson, int hsoff, int ht,
                                  int va, int vson, int vsoff, int fw);
      obs_t o;
      int h, v;
      h = p % ht;
      v = p / ht;
      o.h  = 16'(h);
      o.v  = 16'(v);
      o.hs = (h >= hson) && (h < hsoff);
      o.vs = (v >= vson) && (v < vsoff);
      o.hb = (h >= ha);
      o.vb = (v >= va);
      o.ls = (h == 0);
      o.fs = (p == 0);
      o.fc = 16'(fr % (1 << fw));
      return o;
   endfunction

   function automatic obs_t act_s();
      obs_t o;
      o.h = 16'(hc_s); o.v = 16'(vc_s);
      o.hs = hs_s; o.vs = vs_s; o.hb = hb_s; o.vb = vb_s; o.ls = ls_s; o.fs = fs_s;
      o.fc = 16'(fc_s);
      return o;
   endfunction

   function automatic obs_t act_d();
      obs_t o;
      o.h = 16'(hc_d); o.v = 16'(vc_d);
      o.hs = hs_d; o.vs = vs_d; o.hb = hb_d; o.vb = vb_d; o.ls = ls_d; o.fs = fs_d;
      o.fc = fc_d;
      return o;
   endfunction

   task automatic compare(string name, obs_t e, obs_t a);
      n_checks++;
      if (e !== a) begin
         n_fail++;
         $display("FAIL %s @%0t: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d, expected h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b ls=%b fs=%b fc=%0d",
                  name, $time, a.h, a.v, a.hs, a.vs, a.hb, a.vb, a.ls, a.fs, a.fc,
                  e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.ls, e.fs, e.fc);
      end
   endtask

   task automatic compare_int(string name, int a, int e);
      n_checks++;
      if (a != e) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, a, e);
      end
   endtask

   obs_t q_s[$];
   obs_t q_d[$];
   int   pos_s = 0, fr_s = 0;
   int   pos_d = 0, fr_d = 0;

   // Inputs change just after the falling edge; the expected state after the next rising edge is queued.
   task automatic step_s(bit r, bit e);
      @(negedge clk); #1;
      rst_s = r;
      en_s  = e;
      if (r) begin
         pos_s = 0; fr_s = 0;
      end else if (e) begin
         pos_s++;
         if (pos_s == S_HT * S_VT) begin pos_s = 0; fr_s++; end
      end
      q_s.push_back(model(pos_s, fr_s, S_HA, S_HSON, S_HSOFF, S_HT, S_VA, S_VSON, S_VSOFF, S_FW));
      if (r) begin
         #1 compare("async_reset_s", model(0, 0, S_HA, S_HSON, S_HSOFF, S_HT, S_VA, S_VSON, S_VSOFF, S_FW), act_s());
      end
   endtask

   task automatic step_d(bit r, bit e);
      @(negedge clk); #1;
      rst_d = r;
      en_d  = e;
      if (r) begin
         pos_d = 0; fr_d = 0;
      end else if (e) begin
         pos_d++;
         if (pos_d == D_HT * D_VT) begin pos_d = 0; fr_d++; end
      end
      q_d.push_back(model(pos_d, fr_d, D_HA, D_HSON, D_HSOFF, D_HT, D_VA, D_VSON, D_VSOFF, D_FW));
      if (r) begin
         #1 compare("async_reset_d", model(0, 0, D_HA, D_HSON, D_HSOFF, D_HT, D_VA, D_VSON, D_VSOFF, D_FW), act_d());
      end
   endtask

   // Scoreboard monitors: one pop per cycle, sampled on the falling edge.
   always @(negedge clk) begin
      obs_t e;
      if (q_s.size() > 0) begin
         e = q_s.pop_front();
         compare("scoreboard_s", e, act_s());
      end
      if (q_d.size() > 0) begin
         e = q_d.pop_front();
         compare("scoreboard_d", e, act_d());
      end
   end

   int l1_cnt = 0, l1_hs = 0, l1_hb = 0, l1_ls = 0;
   always @(negedge clk) begin
      if (!rst_d && vc_d == 11'd1) begin
         l1_cnt++;
         if (hs_d) l1_hs++;
         if (hb_d) l1_hb++;
         if (ls_d) l1_ls++;
      end
   end

   task automatic run_small();
      int k;
      step_s(1, 0);
      step_s(1, 0);
      for (int i = 0; i < 300; i++) step_s(0, $urandom_range(0, 9) != 0);
      step_s(1, 1);
      step_s(0, 1);
      k = 0;
      while (pos_s != S_HT * S_VT - 1 && k < 2000) begin step_s(0, 1); k++; end
      for (int i = 0; i < 5; i++) step_s(0, 0);
      step_s(0, 1);
      k = 0;
      while (fr_s < 7 && k < 9000) begin
         step_s(0, $urandom_range(0, 9) != 0);
         k++;
      end
   endtask

   task automatic run_default();
      int k;
      step_d(1, 0);
      step_d(1, 0);
      for (int i = 0; i < 500; i++) step_d(0, 1);
      step_d(1, 1);
      step_d(0, 1);
      k = 0;
      while (pos_d != D_HSON - 1 && k < 2000) begin step_d(0, 1); k++; end
      for (int i = 0; i < 100; i++) step_d(0, 0);
      step_d(0, 1);
      k = 0;
      while (pos_d != 3 * D_HT + 5 && k < 6000) begin step_d(0, 1); k++; end
   endtask

   initial begin
      fork
         run_small();
         run_default();
      join
      repeat (3) @(negedge clk);
      #2;
      compare_int("line1_clocks", l1_cnt, D_HT);
      compare_int("line1_hsync_clocks", l1_hs, D_HSOFF - D_HSON);
      compare_int("line1_hblnk_clocks", l1_hb, D_HT - D_HA);
      compare_int("line1_line_start_pulses", l1_ls, 1);
      compare_int("small_frames_reached", fr_s, 7);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
